adc_scan_sequencer: RTL

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - periodic conversion and readout sequencer for AD7864 ADCs on a shared bus
//
// Purpose: divides clkin into a sample tick and, on each tick, issues one
// common conversion start, waits for every device to drop BUSY, then reads
// CH_NO channels from each of CHIP_NO devices (chip-major) and presents each
// sample as a 16-bit word with a valid/ready handshake.
//
// Ports:
//   clkin        in   single clock, all logic on its rising edge
//   rst          in   synchronous, active-high reset
//   run          in   level; 1 enables periodic scanning
//   busy         in   per-device BUSY, active high
//   db           in   shared 12-bit data bus
//   convst_bar   out  common conversion start, active low
//   cs_bar       out  one-hot-low device select, low only during rd_bar low
//   rd_bar       out  read strobe, active low
//   word         out  {chip[1:0], ch[1:0], data[11:0]}
//   word_valid   out  word holds a valid sample
//   word_ready   in   downstream accepts word
//   frame_start  out  one-cycle pulse on the first word of a scan
//   overrun      out  sticky: tick arrived while a scan was in progress
//   busy_err     out  sticky: BUSY did not release in time
module adc_scan_sequencer #(
  parameter int CHIP_NO  = 4,
  parameter int CH_NO    = 4,
  parameter int RATE_DIV = 1500,
  parameter int CONV_LOW = 3,
  parameter int RD_LOW   = 3,
  parameter int BUSY_TMO = 255
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               run,
  input  logic [CHIP_NO-1:0] busy,
  input  logic [11:0]        db,
  output logic               convst_bar,
  output logic [CHIP_NO-1:0] cs_bar,
  output logic               rd_bar,
  output logic [15:0]        word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               frame_start,
  output logic               overrun,
  output logic               busy_err
);

  localparam int DIV_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int PH_MAX = (BUSY_TMO > CONV_LOW)
                          ? ((BUSY_TMO > RD_LOW) ? BUSY_TMO : RD_LOW)
                          : ((CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RATE_DIV - 1);
  localparam logic [PH_W-1:0]  CONV_LAST = PH_W'(CONV_LOW - 1);
  localparam logic [PH_W-1:0]  RD_LAST   = PH_W'(RD_LOW - 1);
  localparam logic [PH_W-1:0]  TMO_LAST  = PH_W'(BUSY_TMO - 1);
  localparam logic [1:0]       CHIP_LAST = 2'(CHIP_NO - 1);
  localparam logic [1:0]       CH_LAST   = 2'(CH_NO - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_BUSY,
    READ,
    PUSH,
    NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  ph_q, ph_d;        // cycles spent in the current state
  logic [1:0]       chip_q, chip_d;
  logic [1:0]       ch_q, ch_d;
  logic [15:0]      word_q, word_d;
  logic             overrun_q, overrun_d;
  logic             busy_err_q, busy_err_d;
  logic             tick;

  assign word     = word_q;
  assign overrun  = overrun_q;
  assign busy_err = busy_err_q;

  // Sample-rate divider: held at 0 while run is low so the first tick after
  // enabling comes a full period later.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (!run) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    chip_d      = chip_q;
    ch_d        = ch_q;
    word_d      = word_q;
    // A tick is only honoured in IDLE; anywhere else, including the final
    // NEXT cycle of a scan, it is dropped and flagged.
    overrun_d   = overrun_q | (tick & (state_q != IDLE));
    busy_err_d  = busy_err_q;
    convst_bar  = 1'b1;
    cs_bar      = '1;
    rd_bar      = 1'b1;
    word_valid  = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      IDLE: begin
        ph_d   = '0;
        chip_d = '0;
        ch_d   = '0;
        if (tick) begin
          state_d = CONV;
        end
      end

      CONV: begin
        convst_bar = 1'b0;
        if (ph_q == CONV_LAST) begin
          ph_d    = '0;
          state_d = WAIT_BUSY;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      // Cycle 0 ignores busy: the devices need a cycle after convst_bar
      // rises before BUSY is meaningful. A release on the last allowed
      // cycle still wins over the timeout.
      WAIT_BUSY: begin
        if ((ph_q != '0) && (busy == '0)) begin
          ph_d    = '0;
          state_d = READ;
        end else if (ph_q == TMO_LAST) begin
          busy_err_d = 1'b1;
          ph_d       = '0;
          state_d    = IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      READ: begin
        rd_bar = 1'b0;
        cs_bar = ~(CHIP_NO'(1) << chip_q);
        if (ph_q == RD_LAST) begin
          word_d  = {chip_q, ch_q, db};
          ph_d    = '0;
          state_d = PUSH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      // ph_q marks whether this is the first PUSH cycle so frame_start
      // does not repeat while the consumer stalls.
      PUSH: begin
        word_valid  = 1'b1;
        frame_start = (ph_q == '0) && (chip_q == 2'd0) && (ch_q == 2'd0);
        if (word_ready) begin
          ph_d    = '0;
          state_d = NEXT;
        end else begin
          ph_d = PH_W'(1);
        end
      end

      NEXT: begin
        if (ch_q == CH_LAST) begin
          ch_d = '0;
          if (chip_q == CHIP_LAST) begin
            chip_d  = '0;
            state_d = IDLE;
          end else begin
            chip_d  = chip_q + 2'd1;
            state_d = READ;
          end
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = READ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      ph_q       <= '0;
      chip_q     <= '0;
      ch_q       <= '0;
      word_q     <= '0;
      overrun_q  <= 1'b0;
      busy_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      chip_q     <= chip_d;
      ch_q       <= ch_d;
      word_q     <= word_d;
      overrun_q  <= overrun_d;
      busy_err_q <= busy_err_d;
    end
  end

endmodule
